serial_demux: RTL and testbench

Receive-side counterpart of the bit-select multiplexers: a 1-to-WIDTH sequential demultiplexer that takes a serial bit stream and steers each accepted bit into its own lane of a parallel output register. Once all WIDTH lanes are filled, it presents the assembled word with a valid/ready handshake. It sits between any serializer built from the 2:1/4:1 mux tree and the ALU operand registers.

---
 rtl/alu_pkg.sv | 12 +
 rtl/demux_1_to_n.sv | 19 +
 rtl/serial_demux.sv | 111 +++++++++++
 tb/tb_serial_demux.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU-side datapath blocks.
// Holds the serial demux lane default and its two-state FSM encoding.
package alu_pkg;

  localparam int unsigned DEMUX_LANES = 4;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } demux_state_e;

endpackage

// File: rtl/demux_1_to_n.sv
// Combinational 1-to-WIDTH decoder: the decode dual of the bit-select mux tree.
// Produces a one-hot write enable for the selected lane, all-zero when disabled.
module demux_1_to_n #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic             enable,
  input  logic [SEL_W-1:0] select,
  output logic [WIDTH-1:0] lane_we
);

  always_comb begin
    lane_we = '0;
    if (enable) begin
      lane_we = WIDTH'(1) << select;
    end
  end

endmodule

// File: rtl/serial_demux.sv
// Serial-to-parallel demultiplexer: steers accepted bits LSB-first into lanes
// of data_out and presents the full word with a valid/ready handshake.
module serial_demux
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_LANES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       data_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH)-1:0]   lane,
  output logic                       overflow
);

  localparam int unsigned SEL_W = $clog2(WIDTH);
  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(WIDTH - 1);

  demux_state_e     state_q, state_d;
  logic [SEL_W-1:0] lane_d;
  logic             overflow_d;
  logic             in_ready_d;
  logic             out_valid_d;
  logic             write_en_c;
  logic [WIDTH-1:0] lane_we;

  // A clear in the same cycle as a valid bit drops the bit.
  assign write_en_c = in_valid & in_ready & ~clear;

  demux_1_to_n #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_decode (
    .enable  (write_en_c),
    .select  (lane),
    .lane_we (lane_we)
  );

  // State, lane counter, flags and the registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_COLLECT;
      lane      <= '0;
      overflow  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane      <= lane_d;
      overflow  <= overflow_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Lane register bank; clear leaves the stored lanes untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        if (lane_we[k]) begin
          data_out[k] <= data_in;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane;
    overflow_d  = overflow;
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;

    if (clear) begin
      state_d    = ST_COLLECT;
      lane_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        overflow_d = 1'b1;
      end
      unique case (state_q)
        ST_COLLECT: begin
          if (in_valid) begin
            lane_d = lane + SEL_W'(1);
            if (lane == LAST_LANE) begin
              state_d = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_d = ST_COLLECT;
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end

    in_ready_d  = (state_d == ST_COLLECT);
    out_valid_d = (state_d == ST_FULL);
  end

endmodule

// File: tb/tb_serial_demux.sv
// Self-checking bench for serial_demux: directed scenarios plus a random phase,
// compared every cycle against a frame-level behavioural model.
module tb_serial_demux;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             data_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       lane;
  logic             overflow;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  serial_demux #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane      (lane),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: a word is full once WIDTH bits have been taken.
  bit               m_full;
  int               m_cnt;
  logic [WIDTH-1:0] m_word;
  bit               m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full = 0; m_cnt = 0; m_word = '0; m_ovf = 0;
    end else if (clear) begin
      m_full = 0; m_cnt = 0; m_ovf = 0;
    end else if (m_full) begin
      if (in_valid) m_ovf = 1;
      if (out_ready) m_full = 0;
    end else if (in_valid) begin
      m_word[m_cnt] = data_in;
      m_cnt++;
      if (m_cnt == WIDTH) begin
        m_cnt  = 0;
        m_full = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("in_ready",  32'(in_ready),  32'(!m_full));
      chk("out_valid", 32'(out_valid), 32'(m_full));
      chk("lane",      32'(lane),      32'(m_cnt));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("data_out",  32'(data_out),  32'(m_word));
    end
  end

  // Handshake timestamps for the throughput check.
  int cyc_cnt = 0;
  int hs_times[$];
  always @(posedge clk) begin
    cyc_cnt++;
    if (rst_n && out_valid && out_ready) hs_times.push_back(cyc_cnt);
  end

  task automatic cyc(input logic iv, input logic d, input logic ordy, input logic clr);
    in_valid  = iv;
    data_in   = d;
    out_ready = ordy;
    clear     = clr;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic ordy);
    for (int i = 0; i < WIDTH; i++) cyc(1'b1, w[i], ordy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; data_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_lane",      32'(lane),      32'd0);
    chk("rst_data_out",  32'(data_out),  32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    chk_en = 1;

    // Bits 1,0,1,1 with out_ready low.
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    chk("w1_out_valid", 32'(out_valid), 32'd1);
    chk("w1_data",      32'(data_out),  32'h0000000d);
    chk("w1_lane",      32'(lane),      32'd0);
    chk("w1_in_ready",  32'(in_ready),  32'd0);

    // Handshake, then 0,1,1,0 and the next handshake five cycles later.
    cyc(0, 0, 1, 0);
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_in_ready",  32'(in_ready),  32'd1);
    send_word(4'b0110, 1'b0);
    chk("w2_data", 32'(data_out), 32'h00000006);
    cyc(0, 0, 1, 0);
    if (hs_times.size() >= 2)
      chk("hs_spacing", 32'(hs_times[hs_times.size()-1] - hs_times[hs_times.size()-2]), 32'd5);
    else
      chk("hs_count", 32'(hs_times.size()), 32'd2);

    // Two bits, then clear together with in_valid.
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 1);
    chk("clr_lane",     32'(lane),          32'd0);
    chk("clr_overflow", 32'(overflow),      32'd0);
    chk("clr_lo",       32'(data_out[1:0]), 32'd3);
    chk("clr_hi",       32'(data_out[3:2]), 32'd1);
    send_word(4'b1010, 1'b0);
    chk("w3_data", 32'(data_out), 32'h0000000a);
    cyc(0, 0, 1, 0);

    // Overflow in FULL is sticky across the next word until clear.
    send_word(4'b1111, 1'b0);
    cyc(1, 0, 0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    cyc(0, 0, 1, 0);
    send_word(4'b0011, 1'b0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    cyc(0, 0, 0, 1);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("clr_drop_full", 32'(out_valid), 32'd0);

    // Bits 0,0,0,1 with random idle gaps.
    for (int i = 0; i < WIDTH; i++) begin
      int gap = int'($urandom_range(0, 4));
      for (int g = 0; g < gap; g++) cyc(0, 1, 0, 0);
      chk("gap_lane", 32'(lane), 32'(i));
      cyc(1, (i == WIDTH - 1), 0, 0);
    end
    chk("gap_data", 32'(data_out), 32'h00000008);
    cyc(0, 0, 1, 0);

    // Reset pulse after three bits.
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_lane",      32'(lane),      32'd0);
    chk("mid_rst_data",      32'(data_out),  32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(4'b1001, 1'b0);
    chk("post_rst_data", 32'(data_out), 32'h00000009);
    cyc(0, 0, 1, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end
    cyc(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
